// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined logic unit (AND/OR/XOR/pass with optional b/result inversion) with flags,
// valid/ready flow control and a completed-op counter. Define LOGIC_UNIT_PIPE_POPCNT_EN for popcnt.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  input  logic [3:0]                   f,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out,
  output logic [TAG_W-1:0]             out_tag,
  output logic                         zero,
  output logic                         parity,
  output logic [$clog2(WIDTH+1)-1:0]   popcnt,
  output logic [CNT_W-1:0]             ops_done
);

  localparam int unsigned PCNT_W = $clog2(WIDTH + 1);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_f;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_adv;
  logic             s2_load;
  logic             in_xfer;
  logic             out_xfer;
  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] res;

  // Both stages advance together; S1 is free whenever it is empty or S2 can drain.
  assign s2_adv    = ~out_valid | out_ready;
  assign in_ready  = ~s1_valid | s2_adv;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign s2_load   = s2_adv & s1_valid;

  // Op decode from S1 contents
  always_comb begin
    bb  = s1_f[3] ? ~s1_b : s1_b;
    res = s1_a;
    unique case (s1_f[1:0])
      2'b00:   res = s1_a;
      2'b01:   res = s1_a & bb;
      2'b10:   res = s1_a | bb;
      default: res = s1_a ^ bb;
    endcase
    if (s1_f[2]) res = ~res;
  end

  // Stage 1: operand capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_f     <= '0;
      s1_tag   <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_xfer) begin
        s1_a   <= a;
        s1_b   <= b;
        s1_f   <= f;
        s1_tag <= in_tag;
      end
    end
  end

  // Stage 2: result and flags, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_tag   <= '0;
      zero      <= 1'b1;
      parity    <= 1'b0;
    end else begin
      if (s2_adv) out_valid <= s1_valid;
      if (s2_load) begin
        out     <= res;
        out_tag <= s1_tag;
        zero    <= (res == '0);
        parity  <= ^res;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ops_done <= '0;
    else if (out_xfer) ops_done <= ops_done + CNT_W'(1);
  end

`ifdef LOGIC_UNIT_PIPE_POPCNT_EN
  logic [PCNT_W-1:0] res_pcnt;

  always_comb begin
    res_pcnt = '0;
    for (int i = 0; i < int'(WIDTH); i++) res_pcnt = res_pcnt + PCNT_W'(res[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) popcnt <= '0;
    else if (s2_load) popcnt <= res_pcnt;
  end
`else
  assign popcnt = '0;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: driver pushes expected results on accepted inputs,
// a negedge monitor pops and compares on every output transfer.
module tb_logic_unit_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [3:0]  f;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic [3:0]  out_tag;
  logic        zero, parity;
  logic [5:0]  popcnt;
  logic [15:0] ops_done;

  logic_unit_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .f(f), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_tag(out_tag), .zero(zero), .parity(parity), .popcnt(popcnt),
    .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] res; logic [3:0] tag; } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0;
  int accepted = 0, exp_ops = 0, cyc = 0, n_out = 0;
  int first_cyc = 0, last_cyc = 0;
  bit mark = 0, rmode = 0, prev_stall = 0;
  logic [31:0] prev_out;
  logic [3:0]  prev_tag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: b optionally complemented, op picked, result optionally inverted
  function automatic logic [31:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic [3:0] mf);
    logic [31:0] bv, r;
    bv = mf[3] ? ~mb : mb;
    case (mf[1:0])
      2'd0:    r = ma;
      2'd1:    r = ma & bv;
      2'd2:    r = ma | bv;
      default: r = ma ^ bv;
    endcase
    return mf[2] ? ~r : r;
  endfunction

  // Offer one op; returns just after the accepting edge with in_valid still high.
  task automatic send(input logic [31:0] sa, input logic [31:0] sbv, input logic [3:0] sf,
                      input logic [3:0] st, input bit use_c, input logic [31:0] cexp);
    exp_t e;
    bit done = 0;
    in_valid = 1'b1; a = sa; b = sbv; f = sf; in_tag = st;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = use_c ? cexp : model(sa, sbv, sf);
        e.tag = st;
        sb.push_back(e);
        accepted++;
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL send_timeout actual=not_accepted required=accepted tag=%0h", st);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 100 && sb.size() != 0; i++) cycles(1);
    if (sb.size() != 0) begin
      errors++; checks++;
      $display("FAIL drain_timeout actual=%0d required=0 pending", sb.size());
    end
    cycles(1);
  endtask

  // Random consumer backpressure when enabled
  always @(posedge clk) begin
    #1;
    if (rmode) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      exp_ops = 0; prev_stall = 0;
    end else begin
      chk("ops_done", 64'(ops_done), 64'(16'(exp_ops)));
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_out", 64'(out), 64'(prev_out));
        chk("hold_tag", 64'(out_tag), 64'(prev_tag));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_out actual=%0h required=no_output", out);
        end else begin
          e = sb.pop_front();
          chk("out", 64'(out), 64'(e.res));
          chk("out_tag", 64'(out_tag), 64'(e.tag));
          chk("zero", 64'(zero), 64'(e.res == 32'd0));
          chk("parity", 64'(parity), 64'($countones(e.res) % 2));
`ifdef LOGIC_UNIT_PIPE_POPCNT_EN
          chk("popcnt", 64'(popcnt), 64'($countones(e.res)));
`else
          chk("popcnt", 64'(popcnt), 64'd0);
`endif
        end
        exp_ops++; n_out++; last_cyc = cyc;
        if (mark) begin first_cyc = cyc; mark = 0; end
      end
      prev_stall = out_valid && !out_ready;
      prev_out = out; prev_tag = out_tag;
    end
  end

  initial begin
    int base_n;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; f = '0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_parity", 64'(parity), 64'd0);
    chk("rst_popcnt", 64'(popcnt), 64'd0);
    chk("rst_ops_done", 64'(ops_done), 64'd0);
    rst_n = 1'b1;
    cycles(1);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Backpressure: consumer stalled, four ops offered, only two fit
    out_ready = 1'b0;
    fork
      begin
        for (int t = 0; t < 4; t++)
          send($urandom, $urandom, 4'($urandom_range(0, 15)), 4'(t), 0, '0);
        in_valid = 1'b0;
      end
    join_none
    cycles(5);
    chk("bp_accepted", 64'(accepted), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_tag_head", 64'(out_tag), 64'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 50 && accepted < 4; i++) cycles(1);
    chk("bp_accepted_all", 64'(accepted), 64'd4);
    drain();
    chk("bp_ops_done", 64'(ops_done), 64'd4);

    // Directed vectors with fixed expected results, plus latency
    send(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0001, 4'h5, 1, 32'hF000_F000);
    in_valid = 1'b0;
    chk("lat_cycle1", 64'(out_valid), 64'd0);
    cycles(1);
    chk("lat_cycle2", 64'(out_valid), 64'd1);
    chk("lat_out", 64'(out), 64'hF000_F000);
    send(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0111, 4'h6, 1, 32'hF00F_F00F);
    send(32'hF0F0_F0F0, 32'hFF00_FF00, 4'b1010, 4'h7, 1, 32'hF0FF_F0FF);
    send(32'h0000_0000, 32'h1234_5678, 4'b0100, 4'h8, 1, 32'hFFFF_FFFF);
    send(32'hA5A5_0000, 32'hA5A5_0000, 4'b0011, 4'h9, 1, 32'h0000_0000);
    in_valid = 1'b0;
    drain();

    // Back-to-back random burst at full throughput
    base_n = n_out;
    mark = 1;
    for (int i = 0; i < 100; i++)
      send($urandom, $urandom, 4'($urandom_range(0, 15)), 4'(i), 0, '0);
    in_valid = 1'b0;
    drain();
    chk("burst_count", 64'(n_out - base_n), 64'd100);
    chk("burst_span", 64'(last_cyc - first_cyc), 64'd99);
    chk("burst_ops_done", 64'(ops_done), 64'(16'(accepted)));

    // Random producer gaps and consumer stalls
    rmode = 1;
    for (int i = 0; i < 60; i++) begin
      send($urandom, $urandom, 4'($urandom_range(0, 15)), 4'($urandom), 0, '0);
      if ($urandom_range(0, 2) == 0) begin in_valid = 1'b0; cycles($urandom_range(1, 3)); end
    end
    in_valid = 1'b0;
    rmode = 0; out_ready = 1'b1;
    drain();
    chk("rand_ops_done", 64'(ops_done), 64'(16'(accepted)));

    // Reset with two ops in flight
    out_ready = 1'b0;
    send($urandom, $urandom, 4'b0110, 4'hA, 0, '0);
    send($urandom, $urandom, 4'b1001, 4'hB, 0, '0);
    in_valid = 1'b0;
    cycles(1);
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ops_done", 64'(ops_done), 64'd0);
    chk("mid_rst_zero", 64'(zero), 64'd1);
    chk("mid_rst_out", 64'(out), 64'd0);
    sb.delete();
    accepted = 0;
    cycles(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycles(1);
      chk("post_rst_no_out", 64'(out_valid), 64'd0);
    end
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
